// File: rtl/cpu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_pkg
// Shared encodings for the CPU sequencer:
//   - STATE_HALT / STATE_NEXT : decoder state codes the sequencer reacts to
//   - mode_t                  : sequencer operating modes (3-bit encoding)
//   - mode_is_exec()          : true for modes in which the datapath runs
// ---------------------------------------------------------------------------
package cpu_sequencer_pkg;

    // Decoder state codes; these must track the control decoder's encoding.
    localparam logic [3:0] STATE_HALT = 4'd8;
    localparam logic [3:0] STATE_NEXT = 4'd9;

    typedef enum logic [2:0] {
        MODE_PAUSE  = 3'd0,
        MODE_RUN    = 3'd1,
        MODE_STEP   = 3'd2,
        MODE_HALTED = 3'd3,
        MODE_LOAD   = 3'd4
    } mode_t;

    // The datapath is enabled only while an instruction is allowed to execute.
    function automatic logic mode_is_exec(input mode_t m);
        return (m == MODE_RUN) || (m == MODE_STEP);
    endfunction

endpackage

// File: rtl/cpu_sequencer_cycle_counter.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_cycle_counter
// Instruction-cycle counter feeding the control decoder.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance enable (datapath enabled)
//   clr        : force the counter to 0 (loader owns the bus)
//   done       : decoder reports "instruction done" this cycle
//   halt       : decoder reports "halt" this cycle; counter holds
//   cycle      : registered cycle number
//   boundary   : combinational strobe, instruction retires on this clk
// The counter wraps to 0 at a boundary; reaching MAX_CYCLE forces a boundary
// so the count can never run past the last legal cycle.
// ---------------------------------------------------------------------------
module cpu_sequencer_cycle_counter #(
    parameter int CYCLE_W   = 4,
    parameter int MAX_CYCLE = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic               done,
    input  logic               halt,
    output logic [CYCLE_W-1:0] cycle,
    output logic               boundary
);

    logic [CYCLE_W-1:0] cycle_q;
    logic [CYCLE_W-1:0] cycle_d;
    logic               at_max;

    assign at_max   = (cycle_q == CYCLE_W'(MAX_CYCLE));
    // A halt suppresses retirement: the halted instruction is not counted.
    assign boundary = en && !halt && (done || at_max);

    always_comb begin
        cycle_d = cycle_q;
        if (clr) begin
            cycle_d = '0;
        end else if (en && !halt) begin
            if (boundary) begin
                cycle_d = '0;
            end else begin
                cycle_d = cycle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle = cycle_q;

endmodule

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Front-panel sequencer: runs / single-steps / stops / halts the CPU and
// arbitrates the shared bus between the CPU and the program loader. Bus
// ownership only changes at instruction boundaries.
// Ports:
//   clk        : system clock (rising edge)
//   reset      : asynchronous active-low reset
//   state      : current decoder state
//   run/step/stop : one-clk front-panel pulses
//   load_req   : loader bus request (level)
//   cycle      : registered cycle number to the decoder
//   cpu_en     : registered datapath enable (RUN/STEP)
//   load_gnt   : registered loader grant (LOAD)
//   halted     : registered halt indicator (HALTED)
//   instr_cnt  : retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int                 CYCLE_W   = 4,
    parameter int                 STATE_W   = 4,
    parameter int                 MAX_CYCLE = 6,
    parameter logic [STATE_W-1:0] ST_NEXT   = STATE_W'(STATE_NEXT),
    parameter logic [STATE_W-1:0] ST_HALT   = STATE_W'(STATE_HALT),
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state,
    input  logic               run,
    input  logic               step,
    input  logic               stop,
    input  logic               load_req,
    output logic [CYCLE_W-1:0] cycle,
    output logic               cpu_en,
    output logic               load_gnt,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_cnt
);

    mode_t            mode_q, mode_d;
    logic             pend_stop_q, pend_stop_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             cpu_en_q, cpu_en_d;
    logic             load_gnt_q, load_gnt_d;
    logic             halted_q, halted_d;

    logic             boundary;
    logic             halt_hit;
    logic             is_next;
    logic             is_halt;
    logic             cnt_clr;

    assign is_next  = (state == ST_NEXT);
    assign is_halt  = (state == ST_HALT);
    // Decoder state is only meaningful while the datapath is enabled.
    assign halt_hit = cpu_en_q && is_halt;
    // Clearing on the entry edge as well zeroes a cycle frozen by HALTED.
    assign cnt_clr  = (mode_d == MODE_LOAD);

    cpu_sequencer_cycle_counter #(
        .CYCLE_W   (CYCLE_W),
        .MAX_CYCLE (MAX_CYCLE)
    ) u_cycle_counter (
        .clk      (clk),
        .rst_n    (reset),
        .en       (cpu_en_q),
        .clr      (cnt_clr),
        .done     (is_next),
        .halt     (is_halt),
        .cycle    (cycle),
        .boundary (boundary)
    );

    // Next-mode and bookkeeping decode.
    always_comb begin
        mode_d      = mode_q;
        pend_stop_d = pend_stop_q;
        instr_cnt_d = instr_cnt_q;

        if (boundary) begin
            instr_cnt_d = instr_cnt_q + 1'b1;
        end

        case (mode_q)
            MODE_PAUSE: begin
                if (load_req) begin
                    mode_d = MODE_LOAD;
                end else if (step) begin
                    mode_d = MODE_STEP;
                end else if (run) begin
                    mode_d = MODE_RUN;
                end
            end
            MODE_RUN: begin
                if (halt_hit) begin
                    // Halt wins over any pending stop request.
                    mode_d      = MODE_HALTED;
                    pend_stop_d = 1'b0;
                end else if (boundary && (pend_stop_q || stop || load_req)) begin
                    // A request arriving on the boundary clk is honoured here.
                    mode_d      = MODE_PAUSE;
                    pend_stop_d = 1'b0;
                end else if (stop || load_req) begin
                    pend_stop_d = 1'b1;
                end
            end
            MODE_STEP: begin
                if (halt_hit) begin
                    mode_d = MODE_HALTED;
                end else if (boundary) begin
                    mode_d = MODE_PAUSE;
                end
            end
            MODE_HALTED: begin
                if (load_req) begin
                    mode_d = MODE_LOAD;
                end
            end
            MODE_LOAD: begin
                if (!load_req) begin
                    mode_d = MODE_PAUSE;
                end
            end
            default: begin
                mode_d      = MODE_PAUSE;
                pend_stop_d = 1'b0;
            end
        endcase

        // Loader sessions start from a fresh instruction count.
        if ((mode_d == MODE_LOAD) && (mode_q != MODE_LOAD)) begin
            instr_cnt_d = '0;
        end
    end

    // Outputs are registered from the next mode, so they always mirror mode_q.
    always_comb begin
        cpu_en_d   = mode_is_exec(mode_d);
        load_gnt_d = (mode_d == MODE_LOAD);
        halted_d   = (mode_d == MODE_HALTED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q      <= MODE_PAUSE;
            pend_stop_q <= 1'b0;
            instr_cnt_q <= '0;
            cpu_en_q    <= 1'b0;
            load_gnt_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            pend_stop_q <= pend_stop_d;
            instr_cnt_q <= instr_cnt_d;
            cpu_en_q    <= cpu_en_d;
            load_gnt_q  <= load_gnt_d;
            halted_q    <= halted_d;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign load_gnt  = load_gnt_q;
    assign halted    = halted_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed bench for cpu_sequencer: a vector table covering run, stop, step,
// simultaneous stop/boundary, halt and load-from-halt, followed by hand
// sequences for load arbitration in RUN, counter wrap and async reset.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    localparam logic [3:0] S_IDL = 4'd1;
    localparam logic [3:0] S_NXT = 4'd9;
    localparam logic [3:0] S_HLT = 4'd8;

    logic       clk;
    logic       reset;
    logic [3:0] state;
    logic       run;
    logic       step;
    logic       stop;
    logic       load_req;
    logic [3:0] cycle;
    logic       cpu_en;
    logic       load_gnt;
    logic       halted;
    logic [7:0] instr_cnt;

    int total;
    int bad;

    cpu_sequencer #(
        .CYCLE_W   (4),
        .STATE_W   (4),
        .MAX_CYCLE (6),
        .ST_NEXT   (STATE_NEXT),
        .ST_HALT   (STATE_HALT),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .state     (state),
        .run       (run),
        .step      (step),
        .stop      (stop),
        .load_req  (load_req),
        .cycle     (cycle),
        .cpu_en    (cpu_en),
        .load_gnt  (load_gnt),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       step;
        logic       stop;
        logic       load_req;
        logic [3:0] state;
        logic [3:0] e_cycle;
        logic       e_en;
        logic       e_gnt;
        logic       e_halt;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic p,
                                input logic l, input logic [3:0] st,
                                input logic [3:0] ec, input logic ee,
                                input logic eg, input logic eh,
                                input logic [7:0] en);
        vec_t v;
        v.run = r; v.step = s; v.stop = p; v.load_req = l; v.state = st;
        v.e_cycle = ec; v.e_en = ee; v.e_gnt = eg; v.e_halt = eh; v.e_cnt = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ec, input logic ee,
                           input logic eg, input logic eh, input logic [7:0] en);
        chk({tag, ".cycle"},     32'(cycle),     32'(ec));
        chk({tag, ".cpu_en"},    32'(cpu_en),    32'(ee));
        chk({tag, ".load_gnt"},  32'(load_gnt),  32'(eg));
        chk({tag, ".halted"},    32'(halted),    32'(eh));
        chk({tag, ".instr_cnt"}, 32'(instr_cnt), 32'(en));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic p,
                         input logic l, input logic [3:0] st);
        run = r; step = s; stop = p; load_req = l; state = st;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive(0, 0, 0, 0, S_IDL);

        // run, NEXT at cycle 3
        vecs.push_back(mk(1,0,0,0,S_IDL, 0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,S_IDL, 1,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,S_IDL, 2,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,S_IDL, 3,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,S_NXT, 0,1,0,0,1));
        // stop at cycle 1 completes the instruction then pauses
        vecs.push_back(mk(0,0,0,0,S_IDL, 1,1,0,0,1));
        vecs.push_back(mk(0,0,1,0,S_IDL, 2,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,S_IDL, 3,1,0,0,1));
        vecs.push_back(mk(0,0,0,0,S_NXT, 0,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,S_IDL, 0,0,0,0,2));
        // step: NEXT at cycle 6
        vecs.push_back(mk(0,1,0,0,S_IDL, 0,1,0,0,2));
        vecs.push_back(mk(0,0,0,0,S_IDL, 1,1,0,0,2));
        vecs.push_back(mk(0,0,0,0,S_IDL, 2,1,0,0,2));
        vecs.push_back(mk(0,0,1,0,S_IDL, 3,1,0,0,2));
        vecs.push_back(mk(0,0,0,0,S_IDL, 4,1,0,0,2));
        vecs.push_back(mk(0,0,0,0,S_IDL, 5,1,0,0,2));
        vecs.push_back(mk(0,0,0,0,S_IDL, 6,1,0,0,2));
        vecs.push_back(mk(0,0,0,0,S_NXT, 0,0,0,0,3));
        // second step: no NEXT, MAX_CYCLE guard forces the boundary
        vecs.push_back(mk(0,1,0,0,S_IDL, 0,1,0,0,3));
        vecs.push_back(mk(0,0,0,0,S_IDL, 1,1,0,0,3));
        vecs.push_back(mk(0,0,0,0,S_IDL, 2,1,0,0,3));
        vecs.push_back(mk(0,0,0,0,S_IDL, 3,1,0,0,3));
        vecs.push_back(mk(0,0,0,0,S_IDL, 4,1,0,0,3));
        vecs.push_back(mk(0,0,0,0,S_IDL, 5,1,0,0,3));
        vecs.push_back(mk(0,0,0,0,S_IDL, 6,1,0,0,3));
        vecs.push_back(mk(0,0,0,0,S_IDL, 0,0,0,0,4));
        vecs.push_back(mk(0,0,0,0,S_IDL, 0,0,0,0,4));
        // stop on the boundary clk pauses at that boundary
        vecs.push_back(mk(1,0,0,0,S_IDL, 0,1,0,0,4));
        vecs.push_back(mk(0,0,1,0,S_NXT, 0,0,0,0,5));
        vecs.push_back(mk(0,0,0,0,S_IDL, 0,0,0,0,5));
        // halt at cycle 2 overrides a pending stop
        vecs.push_back(mk(1,0,0,0,S_IDL, 0,1,0,0,5));
        vecs.push_back(mk(0,0,1,0,S_IDL, 1,1,0,0,5));
        vecs.push_back(mk(0,0,0,0,S_IDL, 2,1,0,0,5));
        vecs.push_back(mk(0,0,0,0,S_HLT, 2,0,0,1,5));
        vecs.push_back(mk(1,0,0,0,S_IDL, 2,0,0,1,5));
        vecs.push_back(mk(0,1,0,0,S_IDL, 2,0,0,1,5));
        vecs.push_back(mk(0,0,0,0,S_IDL, 2,0,0,1,5));
        // leaving HALTED through a load
        vecs.push_back(mk(0,0,0,1,S_IDL, 0,0,1,0,0));
        vecs.push_back(mk(0,0,0,1,S_IDL, 0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,S_IDL, 0,0,0,0,0));

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        $display("reset: cycle=%0d en=%0d gnt=%0d halt=%0d cnt=%0d",
                 cycle, cpu_en, load_gnt, halted, instr_cnt);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all("reset_rel", 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].run, vecs[i].step, vecs[i].stop, vecs[i].load_req, vecs[i].state);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_cycle, vecs[i].e_en,
                    vecs[i].e_gnt, vecs[i].e_halt, vecs[i].e_cnt);
            $display("vec %0d: in run=%0d step=%0d stop=%0d ld=%0d st=%0d -> cycle=%0d en=%0d gnt=%0d halt=%0d cnt=%0d",
                     i, vecs[i].run, vecs[i].step, vecs[i].stop, vecs[i].load_req,
                     vecs[i].state, cycle, cpu_en, load_gnt, halted, instr_cnt);
        end

        // load_req raised at cycle 2 in RUN waits for the boundary
        drive(1, 0, 0, 0, S_IDL); tick(); chk_all("ld_run", 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, S_IDL); tick(); chk_all("ld_c1", 1, 1, 0, 0, 0);
        tick();                           chk_all("ld_c2", 2, 1, 0, 0, 0);
        drive(0, 0, 0, 1, S_IDL); tick(); chk_all("ld_c3", 3, 1, 0, 0, 0);
        tick();                           chk_all("ld_c4", 4, 1, 0, 0, 0);
        drive(0, 0, 0, 1, S_NXT); tick(); chk_all("ld_bnd", 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, S_IDL); tick(); chk_all("ld_gnt", 0, 0, 1, 0, 0);
        tick();                           chk_all("ld_hold", 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, S_IDL); tick(); chk_all("ld_rel", 0, 0, 0, 0, 0);
        tick();                           chk_all("ld_pause", 0, 0, 0, 0, 0);
        $display("load seq: cycle=%0d en=%0d gnt=%0d cnt=%0d", cycle, cpu_en, load_gnt, instr_cnt);

        // retired-instruction counter wrap: one boundary per clk
        drive(1, 0, 0, 0, S_NXT); tick(); chk_all("wr_run", 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, S_NXT);
        repeat (255) tick();
        chk_all("wr_255", 0, 1, 0, 0, 255);
        tick();
        chk_all("wr_0", 0, 1, 0, 0, 0);
        $display("wrap seq: cnt=%0d", instr_cnt);

        // async reset in the middle of cycle 4
        drive(0, 0, 0, 0, S_IDL);
        repeat (4) tick();
        chk_all("rst_pre", 4, 1, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("rst_async", 0, 0, 0, 0, 0);
        $display("async reset: cycle=%0d en=%0d gnt=%0d halt=%0d cnt=%0d",
                 cycle, cpu_en, load_gnt, halted, instr_cnt);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk_all("rst_after", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
